// File: rtl/rs232_pkg.sv
// Shared types and helpers for the RS-232 8N1 byte receiver.
// Clock-per-bit math lives here so every user derives it the same way.
package rs232_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Counter must hold 0 .. clks-1; keep at least one bit for tiny ratios.
  function automatic int cnt_width(input int clks);
    return (clks <= 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/rs232_sync.sv
// Two-flop synchronizer for an asynchronous level input.
// Both flops reset to RESET_VAL so the line reads idle out of reset.
module rs232_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rs232_byte_rx.sv
// RS-232 8N1 receive front end: synchronizes the line, finds mid-bit
// sample points and assembles LSB-first bytes for the packet stage.
module rs232_byte_rx
  import rs232_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 57600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs232_rx,
  output logic       rs_ena,
  output logic [7:0] byte_data_out,
  output logic       byte_valid,
  output logic       frame_err,
  output logic [2:0] state_dbg
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW           = cnt_width(CLKS_PER_BIT);
  localparam int HALF         = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(HALF - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  // Output protocol: rs_ena is a level covering the frame from confirmed
  // start to stop sample; byte_valid (with frame_err) is a one-cycle pulse on
  // the edge rs_ena falls, and byte_data_out holds until the next such pulse.
  // There is no ready/back-pressure: the consumer must take every pulse.

  rx_state_t          state_q, state_d;
  logic               rx_s;
  logic [CW-1:0]      baud_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift_reg;
  logic               cnt_last, half_last;
  logic               cnt_clr, start_ok, bit_take, stop_take;

  rs232_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rs232_rx),
    .q   (rx_s)
  );

  assign cnt_last  = (baud_cnt == LAST_CNT);
  assign half_last = (baud_cnt == HALF_CNT);
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s) state_d = START;
      START:   if (half_last) state_d = rx_s ? IDLE : DATA;
      DATA:    if (cnt_last && (bit_idx == LAST_BIT)) state_d = STOP;
      STOP:    if (cnt_last) state_d = rx_s ? IDLE : BREAK;
      // A held-low line must go high before another start is accepted.
      BREAK:   if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr   = 1'b1;
    start_ok  = 1'b0;
    bit_take  = 1'b0;
    stop_take = 1'b0;
    case (state_q)
      START: begin
        cnt_clr  = half_last;
        start_ok = half_last & ~rx_s;
      end
      DATA: begin
        cnt_clr  = cnt_last;
        bit_take = cnt_last;
      end
      STOP: begin
        cnt_clr   = cnt_last;
        stop_take = cnt_last;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      baud_cnt      <= '0;
      bit_idx       <= 3'd0;
      shift_reg     <= 8'h00;
      rs_ena        <= 1'b0;
      byte_data_out <= 8'h00;
      byte_valid    <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      baud_cnt   <= cnt_clr ? '0 : baud_cnt + 1'b1;
      byte_valid <= stop_take;
      frame_err  <= stop_take & ~rx_s;
      if (start_ok) begin
        rs_ena  <= 1'b1;
        bit_idx <= 3'd0;
      end
      if (bit_take) begin
        shift_reg[bit_idx] <= rx_s;
        bit_idx            <= bit_idx + 3'd1;
      end
      // Bytes with a bad stop bit are still delivered; frame_err flags them.
      if (stop_take) begin
        byte_data_out <= shift_reg;
        rs_ena        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rs232_byte_rx.sv
// Bench for rs232_byte_rx: a fast instance (10 clks/bit) driven with directed
// and random frames, plus a default-rate instance for one long frame.
module tb_rs232_byte_rx;
  import rs232_pkg::*;

  localparam int CPB   = 10;
  localparam int HALF  = CPB / 2;
  localparam int CPB2  = 50000000 / 57600;
  localparam int HALF2 = CPB2 / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic       rx2 = 1'b1;
  logic       rs_ena, byte_valid, frame_err;
  logic [7:0] byte_data_out;
  logic [2:0] state_dbg;
  logic       rs_ena2, byte_valid2, frame_err2;
  logic [7:0] byte_data_out2;
  logic [2:0] state_dbg2;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Expected byte events: {valid_cycle[31:0], frame_err, data[7:0]}
  logic [40:0] exp_q[$];
  logic [31:0] rise_q[$];

  rs232_byte_rx #(.CLK_FREQ(1000000), .BAUD(100000)) dut (
    .clk           (clk),
    .rst           (rst),
    .rs232_rx      (rx),
    .rs_ena        (rs_ena),
    .byte_data_out (byte_data_out),
    .byte_valid    (byte_valid),
    .frame_err     (frame_err),
    .state_dbg     (state_dbg)
  );

  rs232_byte_rx dut2 (
    .clk           (clk),
    .rst           (rst),
    .rs232_rx      (rx2),
    .rs_ena        (rs_ena2),
    .byte_data_out (byte_data_out2),
    .byte_valid    (byte_valid2),
    .frame_err     (frame_err2),
    .state_dbg     (state_dbg2)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Driver tasks: inputs change on the falling edge only
  task automatic line_hold(input logic v, input int n);
    @(negedge clk);
    rx = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic line2_hold(input logic v, input int n);
    @(negedge clk);
    rx2 = v;
    repeat (n - 1) @(negedge clk);
  endtask

  // Start is the first rising edge that samples the line low; the confirmed
  // start appears 2 (sync) + HALF clocks later and the stop sample 9 bit
  // times after that.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    int s;
    @(negedge clk);
    rx = 1'b0;
    s  = cyc + 1;
    rise_q.push_back(32'(s + 2 + HALF));
    exp_q.push_back({32'(s + 2 + HALF + 9 * CPB), ~stop_bit, b});
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) line_hold(b[i], CPB);
    line_hold(stop_bit, CPB);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (((exp_q.size() != 0) || (rise_q.size() != 0)) && (n < 2000)) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain_bytes"}, exp_q.size(), 0);
    check({tag, "_drain_rises"}, rise_q.size(), 0);
  endtask

  // Scoreboard / monitor for the fast instance
  logic        prev_ena   = 1'b0;
  logic        prev_valid = 1'b0;
  logic [7:0]  held       = 8'h00;
  logic [40:0] e;

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      prev_ena   = 1'b0;
      prev_valid = 1'b0;
      held       = 8'h00;
    end else begin
      if (rs_ena && !prev_ena) begin
        if (rise_q.size() == 0) check("ena_rise_unexpected", 1, 0);
        else check("ena_rise_time", cyc, rise_q.pop_front());
        check("data_held", byte_data_out, held);
      end
      if (!rs_ena && prev_ena) check("ena_fall_with_valid", byte_valid, 1);
      if (byte_valid) begin
        if (exp_q.size() == 0) check("valid_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("valid_time", cyc, e[40:9]);
          check("byte_data", byte_data_out, e[7:0]);
          check("frame_err", frame_err, e[8]);
          held = e[7:0];
        end
      end else if (frame_err) check("err_without_valid", 1, 0);
      if (byte_valid && prev_valid) check("valid_width", 1, 0);
      prev_ena   = rs_ena;
      prev_valid = byte_valid;
    end
  end

  // Recorder for the default-rate instance
  int         v2_cnt = 0;
  int         v2_cyc = 0;
  int         r2_cyc = 0;
  logic [7:0] v2_data = 8'h00;
  logic       v2_err  = 1'b0;
  logic       prev2   = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      if (byte_valid2) begin
        v2_cnt++;
        v2_cyc  = cyc;
        v2_data = byte_data_out2;
        v2_err  = frame_err2;
      end
      if (rs_ena2 && !prev2) r2_cyc = cyc;
      prev2 = rs_ena2;
    end
  end

  initial begin
    logic [7:0] b;
    logic [7:0] fb;
    logic       stp;
    int         s2;

    repeat (3) @(negedge clk);
    check("rst_ena", rs_ena, 0);
    check("rst_data", byte_data_out, 0);
    check("rst_valid", byte_valid, 0);
    check("rst_err", frame_err, 0);
    check("rst_state", state_dbg, IDLE);
    @(negedge clk);
    rst = 1'b1;
    line_hold(1'b1, 5);

    // Single frame
    send_frame(8'hAA, 1'b1);
    line_hold(1'b1, 10);
    wait_drain("single");

    // Back-to-back frames, no idle gap
    send_frame(8'hAA, 1'b1);
    send_frame(8'hAA, 1'b1);
    send_frame(8'h20, 1'b1);
    send_frame(8'h02, 1'b1);
    line_hold(1'b1, 10);
    wait_drain("b2b");

    // Short low glitch on an idle line
    line_hold(1'b0, 3);
    line_hold(1'b1, 30);
    check("glitch_state", state_dbg, IDLE);
    check("glitch_ena", rs_ena, 0);

    // Low stop bit followed by a held-low line
    send_frame(8'h55, 1'b0);
    line_hold(1'b0, 30);
    check("break_ena", rs_ena, 0);
    line_hold(1'b1, 20);
    wait_drain("break");
    send_frame(8'h81, 1'b1);
    line_hold(1'b1, 10);
    wait_drain("after_break");

    // Reset in the middle of data bit 4
    fb = 8'hF0;
    @(negedge clk);
    rx = 1'b0;
    rise_q.push_back(32'(cyc + 1 + 2 + HALF));
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 4; i++) line_hold(fb[i], CPB);
    line_hold(fb[4], 5);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_ena", rs_ena, 0);
    check("midrst_data", byte_data_out, 0);
    check("midrst_valid", byte_valid, 0);
    check("midrst_state", state_dbg, IDLE);
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    line_hold(1'b1, 20);
    send_frame(8'h3C, 1'b1);
    line_hold(1'b1, 10);
    wait_drain("midrst");

    // Random frames, stop bits and gaps
    for (int k = 0; k < 20; k++) begin
      b   = 8'($urandom_range(0, 255));
      stp = ($urandom_range(0, 3) != 0);
      send_frame(b, stp);
      if (!stp) begin
        int n = $urandom_range(0, 20);
        if (n > 0) line_hold(1'b0, n);
        line_hold(1'b1, $urandom_range(2, 12));
      end else if ($urandom_range(0, 2) != 0) begin
        line_hold(1'b1, $urandom_range(1, 15));
      end
    end
    line_hold(1'b1, 10);
    wait_drain("random");

    // Default rate instance, one frame of 8'h02
    b = 8'h02;
    @(negedge clk);
    rx2 = 1'b0;
    s2  = cyc + 1;
    repeat (CPB2 - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) line2_hold(b[i], CPB2);
    line2_hold(1'b1, CPB2);
    line2_hold(1'b1, 50);
    check("dflt_valid_count", v2_cnt, 1);
    check("dflt_rise_time", r2_cyc, s2 + 2 + HALF2);
    check("dflt_valid_time", v2_cyc, s2 + 2 + HALF2 + 9 * CPB2);
    check("dflt_data", v2_data, 8'h02);
    check("dflt_err", v2_err, 0);
    check("dflt_ena_low", rs_ena2, 0);
    check("dflt_state", state_dbg2, IDLE);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
